spi_led_slave: RTL and testbench
================================

SPI_LED_SLAVE -- requirements
Module: spi_led_slave

Interface
REQ-001 Parameter REG_WIDTH, default 8, SHALL set frame length in bits and data-port width.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set flip-flop depth of the cs/sclk/mosi input synchronizers.
REQ-003 sys_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 cs  input  1  SHALL be the SPI chip select from the master; active low.
REQ-006 sclk  input  1  SHALL be the SPI clock from the master; idle low; data sampled on rising edge.
REQ-007 mosi  input  1  SHALL be serial data from the master, MSB first.
REQ-008 miso  output  1  SHALL be serial data to the master; high-Z while cs high.
REQ-009 tx_data  input  REG_WIDTH  SHALL be the response byte, captured at frame start.
REQ-010 rx_data  output  REG_WIDTH  SHALL be the last accepted received frame.
REQ-011 rx_valid  output  1  SHALL flag rx_data as holding unconsumed data.
REQ-012 rx_ready  input  1  SHALL be the consumer acknowledge; transfer when rx_valid && rx_ready.
REQ-013 frame_err  output  1  SHALL pulse for one cycle on a frame with bit count != REG_WIDTH.
REQ-014 overrun  output  1  SHALL pulse for one cycle when a complete frame is dropped.
REQ-015 busy  output  1  SHALL be high while the FSM is not in IDLE.

Function
REQ-016 cs, sclk and mosi SHALL pass through SYNC_STAGES flops; edges are detected on synchronized values only.
REQ-017 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-018 IDLE->SHIFT on synchronized cs falling edge; tx_data is loaded into the tx shift register and the bit counter is cleared in that cycle.
REQ-019 In SHIFT, each synchronized sclk rising edge SHALL shift mosi into the rx shift register LSB end and increment the counter; the counter saturates at REG_WIDTH+1.
REQ-020 In SHIFT, each synchronized sclk falling edge SHALL shift the tx register left; miso drives the tx register MSB while cs is low.
REQ-021 SHIFT->DONE on synchronized cs rising edge; DONE->IDLE unconditionally after one cycle.
REQ-022 In DONE with counter == REG_WIDTH: if rx_valid is low, or rx_ready is high in that cycle, rx_data SHALL load the shift register and rx_valid SHALL be set; otherwise the frame is dropped and overrun pulses.
REQ-023 In DONE with counter != REG_WIDTH, frame_err SHALL pulse, and rx_data/rx_valid SHALL be unchanged.
REQ-024 rx_valid SHALL clear the cycle after rx_valid && rx_ready, unless it is reloaded in the same cycle per REQ-022.
REQ-025 rx_valid SHALL rise exactly SYNC_STAGES+2 sys_clk cycles after the cs rising edge at the pin.
REQ-026 sclk edges while cs is high SHALL be ignored.
REQ-027 sclk high and low phases SHALL each be at least SYNC_STAGES+1 sys_clk periods; shorter phases give undefined data.

Reset
REQ-028 While rst is high: FSM=IDLE; shift registers, counter and rx_data = 0; rx_valid, frame_err, overrun, busy = 0; synchronizers load 1 for cs and 0 for sclk/mosi.
REQ-029 rst asserted mid-frame SHALL abort the frame; after release, the next frame starts only on a new cs falling edge.

Configuration
REQ-030 Macro SPI_LED_SLAVE_ECHO_EN defined: the tx register SHALL load the current rx_data at frame start, and tx_data is ignored.
REQ-031 Macro SPI_LED_SLAVE_ECHO_EN undefined: the tx register SHALL load tx_data; behaviour otherwise identical.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE=0, SHIFT=1, DONE=2), a 2-bit state type, and the default REG_WIDTH constant.
REQ-033 The input synchronizer SHALL be sub-module spi_sync (parameter SYNC_STAGES, reset value), instantiated three times.

Verification
REQ-034 8-bit frame 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid high SYNC_STAGES+2 cycles after cs rise, then clears next cycle.
REQ-035 tx_data=0x3C, frame 0x00 -> master samples 0x3C on miso; miso high-Z before and after cs.
REQ-036 Two frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun pulses once, rx_valid stays high.
REQ-037 Frame of 5 sclk pulses -> frame_err pulses once, rx_valid stays 0.
REQ-038 rst pulse after 4 bits, then full frame 0x81 -> rx_data=0x81, no frame_err.
REQ-039 ECHO_EN build: send 0x5A then 0xFF -> second frame returns 0x5A on miso.

Source files
------------

// File: rtl/spi_led_slave_pkg.sv
// rtl/spi_led_slave_pkg.sv - shared FSM encoding and defaults for spi_led_slave
// Contents: state_t (IDLE=0, SHIFT=1, DONE=2), DEFAULT_REG_WIDTH, cnt_width()
package spi_led_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_REG_WIDTH = 8;

    // Bit counter must hold REG_WIDTH+1 (saturation value marking "too long").
    function automatic int cnt_width(input int reg_width);
        return $clog2(reg_width + 2);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop input synchronizer with configurable reset value
// Ports: sys_clk, rst (async, active-high), d (async input), q (synchronized output)
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ff <= {SYNC_STAGES{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_led_slave.sv
// rtl/spi_led_slave.sv - SPI mode-0 slave with one-deep rx holding register
// Ports: sys_clk, rst (async, active-high), cs/sclk/mosi/miso (SPI pins),
//        tx_data (response, captured at frame start), rx_data/rx_valid/rx_ready
//        (received frame handshake), frame_err, overrun (1-cycle pulses), busy.
// Build option: SPI_LED_SLAVE_ECHO_EN - respond with the last rx_data instead of tx_data.
module spi_led_slave
    import spi_led_slave_pkg::*;
#(
    parameter int REG_WIDTH   = DEFAULT_REG_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output tri                   miso,
    input  logic [REG_WIDTH-1:0] tx_data,
    output logic [REG_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = cnt_width(REG_WIDTH);

    logic cs_s, sclk_s, mosi_s;
    logic cs_d, sclk_d;
    logic [SYNC_STAGES-1:0] prime;
    logic armed;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    state_t                 state;
    logic [REG_WIDTH-1:0]   tx_sr;
    logic [REG_WIDTH-1:0]   rx_sr;
    logic [CW-1:0]          bit_cnt;
    logic [REG_WIDTH-1:0]   tx_load;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (cs),
        .q       (cs_s)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (sclk),
        .q       (sclk_s)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (mosi),
        .q       (mosi_s)
    );

    // The cs synchronizer comes out of reset holding 1. If the pin is still
    // low (reset hit mid-frame) that flush would look like a falling edge, so
    // a falling edge only counts once cs has been seen high after the
    // synchronizer has fully refilled with real pin samples.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cs_d   <= 1'b1;
            sclk_d <= 1'b0;
            prime  <= '0;
            armed  <= 1'b0;
        end else begin
            cs_d     <= cs_s;
            sclk_d   <= sclk_s;
            prime[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                prime[i] <= prime[i-1];
            end
            armed <= armed | (prime[SYNC_STAGES-1] & cs_s);
        end
    end

    assign cs_fall   = armed & cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

`ifdef SPI_LED_SLAVE_ECHO_EN
    logic unused_tx_data;
    assign unused_tx_data = ^tx_data;
    assign tx_load        = rx_data;
`else
    assign tx_load = tx_data;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        tx_sr   <= tx_load;
                    end
                end

                ST_SHIFT: begin
                    if (cs_rise) begin
                        state <= ST_DONE;
                    end else begin
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[REG_WIDTH-2:0], mosi_s};
                            if (bit_cnt != CW'(REG_WIDTH + 1)) begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        if (sclk_fall) begin
                            tx_sr <= {tx_sr[REG_WIDTH-2:0], 1'b0};
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (bit_cnt == CW'(REG_WIDTH)) begin
                        // A consumer ack in this same cycle frees the slot.
                        if (!rx_valid || rx_ready) begin
                            rx_data  <= rx_sr;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tri-state follows the raw pin so the bus is released immediately.
    assign miso = cs ? 1'bz : tx_sr[REG_WIDTH-1];

endmodule

// File: tb/tb_spi_led_slave.sv
// tb/tb_spi_led_slave.sv - directed self-checking bench for spi_led_slave
// Build option: SPI_LED_SLAVE_ECHO_EN selects the echo expectations.
module tb_spi_led_slave;

    localparam int HALF = 5;

    logic       sys_clk;
    logic       rst;
    logic       cs;
    logic       sclk;
    logic       mosi;
    wire        miso;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    pullup (miso);

    spi_led_slave #(.REG_WIDTH(8), .SYNC_STAGES(2)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun)   ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Lowers cs and clocks nbits out of d (MSB first); cs is left low.
    task automatic spi_bits(input logic [15:0] d, input int nbits, output logic [15:0] got);
        got = '0;
        @(negedge sys_clk);
        cs = 1'b0;
        wait_cyc(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = d[nbits-1-i];
            wait_cyc(HALF);
            got  = {got[14:0], miso};
            sclk = 1'b1;
            wait_cyc(HALF);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic end_frame;
        @(negedge sys_clk);
        cs = 1'b1;
    endtask

    // Cycles from the cs rise until rx_valid is seen; 20 means it never rose.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (!rx_valid && n < 20);
    endtask

    logic [15:0] got;
    int          lat;
    int          fe0;
    logic [7:0]  exp_echo;

    initial begin
        rst      = 1'b1;
        cs       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        rx_ready = 1'b1;
        tx_data  = 8'h00;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        wait_cyc(6);

        // Response path: miso floats outside the frame, tx_data shifts out.
        tx_data = 8'h3C;
        chk("miso_z_before", {31'd0, miso}, 32'd1);
        spi_bits(16'h0000, 8, got);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
`ifdef SPI_LED_SLAVE_ECHO_EN
        chk("miso_resp", {24'd0, got[7:0]}, 32'h00);
`else
        chk("miso_resp", {24'd0, got[7:0]}, 32'h3C);
`endif
        end_frame();
        wait_valid(lat);
        chk("rx_00", {24'd0, rx_data}, 32'h00);
        #2;
        chk("miso_z_after", {31'd0, miso}, 32'd1);
        wait_cyc(10);

        // Basic receive and valid latency.
        spi_bits(16'h00A5, 8, got);
        end_frame();
        wait_valid(lat);
        chk("valid_latency", lat, 32'd4);
        chk("rx_A5", {24'd0, rx_data}, 32'hA5);
        @(posedge sys_clk);
        #1;
        chk("valid_clear", {31'd0, rx_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        wait_cyc(10);

        // Overrun: second frame dropped while first is unconsumed.
        rx_ready = 1'b0;
        spi_bits(16'h0011, 8, got);
        end_frame();
        wait_valid(lat);
        chk("rx_11", {24'd0, rx_data}, 32'h11);
        wait_cyc(10);
        spi_bits(16'h0022, 8, got);
        end_frame();
        wait_cyc(10);
        chk("ovr_count", ov_cnt, 32'd1);
        chk("ovr_rx_keep", {24'd0, rx_data}, 32'h11);
        chk("ovr_valid_hold", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        wait_cyc(2);
        chk("ovr_drain", {31'd0, rx_valid}, 32'd0);
        wait_cyc(10);

        // Short frame.
        spi_bits(16'h0015, 5, got);
        end_frame();
        wait_cyc(10);
        chk("short_ferr", fe_cnt, 32'd1);
        chk("short_no_valid", {31'd0, rx_valid}, 32'd0);
        chk("short_rx_keep", {24'd0, rx_data}, 32'h11);

        // Long frame (9 bits) also rejected.
        spi_bits(16'h01FF, 9, got);
        end_frame();
        wait_cyc(10);
        chk("long_ferr", fe_cnt, 32'd2);
        chk("long_no_valid", {31'd0, rx_valid}, 32'd0);

        // Reset mid-frame, then a clean frame.
        spi_bits(16'h000F, 4, got);
        @(negedge sys_clk);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(10);
        chk("rst_abort_idle", {31'd0, busy}, 32'd0);
        chk("rst_abort_rx", {24'd0, rx_data}, 32'h00);
        end_frame();
        wait_cyc(10);
        fe0 = fe_cnt;
        spi_bits(16'h0081, 8, got);
        end_frame();
        wait_valid(lat);
        chk("rx_81", {24'd0, rx_data}, 32'h81);
        wait_cyc(5);
        chk("rx_81_no_ferr", fe_cnt - fe0, 32'd0);

        // Echo: second frame's response is the first frame's data.
        spi_bits(16'h005A, 8, got);
        end_frame();
        wait_valid(lat);
        chk("rx_5A", {24'd0, rx_data}, 32'h5A);
        wait_cyc(10);
        tx_data = 8'hC3;
        spi_bits(16'h00FF, 8, got);
`ifdef SPI_LED_SLAVE_ECHO_EN
        exp_echo = 8'h5A;
`else
        exp_echo = 8'hC3;
`endif
        chk("second_resp", {24'd0, got[7:0]}, {24'd0, exp_echo});
        end_frame();
        wait_valid(lat);
        chk("rx_FF", {24'd0, rx_data}, 32'hFF);
        wait_cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
